// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - burst/lock-aware AHB bus arbiter; define AHB_ARB_FIXED_PRIO_EN for fixed priority (default round-robin)
module ahb_arbiter #(
  parameter int MAT_NUM       = 4,
  parameter int HMASTER_WIDTH = 8,
  parameter int HBURST_WIDTH  = 3
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [MAT_NUM-1:0]       hbusreq,
  input  logic [MAT_NUM-1:0]       hlock,
  input  logic [1:0]               htrans,
  input  logic [HBURST_WIDTH-1:0]  hburst,
  input  logic                     hready,
  output logic [MAT_NUM-1:0]       hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic                     hmastlock
);

  localparam int IDX_W = (MAT_NUM > 1) ? $clog2(MAT_NUM) : 1;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [MAT_NUM-1:0]       grant_q, grant_d;
  logic [HMASTER_WIDTH-1:0] hmaster_q, hmaster_d;
  logic                     hmastlock_q, hmastlock_d;

  logic                     arb_en;
  logic [IDX_W-1:0]         owner_idx;
  logic                     owner_req;
  logic                     owner_lock;
  logic                     fixed_burst;
  logic [3:0]               burst_len_m1;
  logic [IDX_W-1:0]         win_idx;
  logic                     win_found;

  assign hgrant    = grant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

  // Binary index of the current grant holder (grant is always one-hot)
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < MAT_NUM; i++) begin
      if (grant_q[i]) begin
        owner_idx = IDX_W'(i);
      end
    end
  end

  assign owner_req  = hbusreq[owner_idx];
  assign owner_lock = hlock[owner_idx];

  // Fixed-length burst decode: beats minus one, so the NONSEQ beat is already counted
  always_comb begin
    fixed_burst  = 1'b0;
    burst_len_m1 = 4'd0;
    case (hburst)
      HBURST_WIDTH'(2), HBURST_WIDTH'(3): begin
        fixed_burst  = 1'b1;
        burst_len_m1 = 4'd3;
      end
      HBURST_WIDTH'(4), HBURST_WIDTH'(5): begin
        fixed_burst  = 1'b1;
        burst_len_m1 = 4'd7;
      end
      HBURST_WIDTH'(6), HBURST_WIDTH'(7): begin
        fixed_burst  = 1'b1;
        burst_len_m1 = 4'd15;
      end
      default: begin
        fixed_burst  = 1'b0;
        burst_len_m1 = 4'd0;
      end
    endcase
  end

`ifdef AHB_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = MAT_NUM - 1; i >= 0; i--) begin
      if (hbusreq[i]) begin
        win_idx   = IDX_W'(i);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Round-robin: scan from pointer+1 upward with wrap; pointer itself is checked last
  always_comb begin
    logic [IDX_W:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = MAT_NUM; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(MAT_NUM)) begin
        cand = cand - (IDX_W + 1)'(MAT_NUM);
      end
      if (hbusreq[cand[IDX_W-1:0]]) begin
        win_idx   = cand[IDX_W-1:0];
        win_found = 1'b1;
      end
    end
  end

  // Pointer follows the winner; an empty arbitration leaves it alone
  always_comb begin
    ptr_d = ptr_q;
    if (hready && arb_en && win_found) begin
      ptr_d = win_idx;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // State register: everything holds while hready is low, reset wins regardless
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_ARB;
      cnt_q       <= 4'd0;
      grant_q     <= MAT_NUM'(1);
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  // Next-state: decide whether the grant is held or re-arbitrated on this accepted edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arb_en  = 1'b0;
    if (hready) begin
      case (state_q)
        ST_ARB: begin
          if (owner_lock && owner_req) begin
            state_d = ST_LOCK;
          end else if ((htrans == TR_NONSEQ) && fixed_burst) begin
            state_d = ST_BURST;
            cnt_d   = burst_len_m1;
          end else if (owner_req && (hburst == HBURST_WIDTH'(1)) && (htrans != TR_IDLE)) begin
            state_d = ST_ARB;
          end else begin
            arb_en = 1'b1;
          end
        end
        ST_BURST: begin
          case (htrans)
            TR_SEQ: begin
              if (cnt_q == 4'd1) begin
                state_d = ST_ARB;
                cnt_d   = 4'd0;
                arb_en  = 1'b1;
              end else begin
                cnt_d = cnt_q - 4'd1;
              end
            end
            TR_BUSY: begin
              state_d = ST_BURST;
            end
            default: begin
              // IDLE or NONSEQ ends the burst early
              state_d = ST_ARB;
              cnt_d   = 4'd0;
              arb_en  = 1'b1;
            end
          endcase
        end
        ST_LOCK: begin
          // Release returns to ARB with the grant held for one more accepted cycle
          if (!owner_lock) begin
            state_d = ST_ARB;
          end
        end
        default: begin
          state_d = ST_ARB;
        end
      endcase
    end
  end

  // Outputs: hmaster/hmastlock track the old owner, grant moves only on arbitration
  always_comb begin
    grant_d     = grant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (hready) begin
      hmaster_d   = HMASTER_WIDTH'(owner_idx);
      hmastlock_d = owner_lock;
      if (arb_en) begin
        grant_d = '0;
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
        end else begin
          grant_d[0] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - self-checking bench for ahb_arbiter with directed scenarios and a randomized reference-model run
module tb_ahb_arbiter;
  localparam int N   = 4;
  localparam int HMW = 8;
  localparam int HBW = 3;

  logic           hclk = 1'b0;
  logic           hreset;
  logic [N-1:0]   hbusreq;
  logic [N-1:0]   hlock;
  logic [1:0]     htrans;
  logic [HBW-1:0] hburst;
  logic           hready;
  logic [N-1:0]   hgrant;
  logic [HMW-1:0] hmaster;
  logic           hmastlock;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: owner index, pointer, remaining burst beats, lock flag
  int m_owner;
  int m_ptr;
  int m_beats_left;
  bit m_locked;
  int m_hmaster;
  bit m_hmastlock;

  ahb_arbiter #(.MAT_NUM(N), .HMASTER_WIDTH(HMW), .HBURST_WIDTH(HBW)) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
        d = i + 1;
`else
        d = (i - ptr + N) % N;
        if (d == 0) d = N;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_owner      = 0;
    m_ptr        = 0;
    m_beats_left = 0;
    m_locked     = 0;
    m_hmaster    = 0;
    m_hmastlock  = 0;
  endtask

  task automatic model_edge();
    int o;
    int w;
    bit rearb;
    o           = m_owner;
    m_hmaster   = o;
    m_hmastlock = hlock[o];
    rearb       = 0;
    if (m_locked) begin
      if (!hlock[o]) m_locked = 0;
    end else if (m_beats_left > 0) begin
      if (htrans == 2'b11) begin
        m_beats_left--;
        if (m_beats_left == 0) rearb = 1;
      end else if (htrans != 2'b01) begin
        m_beats_left = 0;
        rearb        = 1;
      end
    end else if (hlock[o] && hbusreq[o]) begin
      m_locked = 1;
    end else if (htrans == 2'b10 && hburst >= 2) begin
      m_beats_left = (4 << ((int'(hburst) >> 1) - 1)) - 1;
    end else if (!(hbusreq[o] && hburst == 1 && htrans != 2'b00)) begin
      rearb = 1;
    end
    if (rearb) begin
      w = pick(hbusreq, m_ptr);
      if (w < 0) begin
        m_owner = 0;
      end else begin
        m_owner = w;
        m_ptr   = w;
      end
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    if (hreset) model_reset();
    else if (hready) model_edge();
    #1;
  endtask

  task automatic test_reset();
    hreset = 1; hbusreq = 4'b1111; hlock = '0; htrans = 2'b10; hburst = '0; hready = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (hgrant !== 4'b0001) $display("FAIL reset_hgrant[%0d] got %b exp 0001", c, hgrant);
      else n_pass++;
      n_checks++;
      if (hmaster !== 8'd0) $display("FAIL reset_hmaster[%0d] got %0d exp 0", c, hmaster);
      else n_pass++;
      n_checks++;
      if (hmastlock !== 1'b0) $display("FAIL reset_hmastlock[%0d] got %b exp 0", c, hmastlock);
      else n_pass++;
    end
    hreset = 0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [4];
    int           exp_m [4];
`ifdef AHB_ARB_FIXED_PRIO_EN
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
    exp_m = '{0, 1, 1, 1};
`else
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    exp_m = '{0, 1, 2, 3};
`endif
    hbusreq = 4'b1110; htrans = 2'b10; hburst = 3'd0; hready = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (hgrant !== exp_g[c]) $display("FAIL rr_hgrant[%0d] got %b exp %b", c, hgrant, exp_g[c]);
      else n_pass++;
      n_checks++;
      if (hmaster !== HMW'(exp_m[c])) $display("FAIL rr_hmaster[%0d] got %0d exp %0d", c, hmaster, exp_m[c]);
      else n_pass++;
    end
  endtask

  task automatic test_fixed_burst();
    logic [N-1:0] exp_last;
`ifdef AHB_ARB_FIXED_PRIO_EN
    exp_last = 4'b0010;
`else
    exp_last = 4'b1000;
`endif
    hbusreq = 4'b1010; htrans = 2'b10; hburst = 3'd3; hready = 1;
    tick();
    htrans = 2'b11; hready = 0;
    tick();
    tick();
    hready = 1;
    tick();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (hgrant !== 4'b0010) $display("FAIL burst_hold[%0d] got %b exp 0010", c, hgrant);
      else n_pass++;
      if (c == 0) tick();
    end
    n_checks++;
    if (hmaster !== 8'd1) $display("FAIL burst_hmaster got %0d exp 1", hmaster);
    else n_pass++;
    tick();
    n_checks++;
    if (hgrant !== exp_last) $display("FAIL burst_end_hgrant got %b exp %b", hgrant, exp_last);
    else n_pass++;
  endtask

  task automatic test_hready_freeze();
    logic [N-1:0] g0;
    logic [HMW-1:0] m0;
    g0 = hgrant; m0 = hmaster;
    hbusreq = 4'b0101; htrans = 2'b10; hburst = 3'd0; hready = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (hgrant !== g0 || hmaster !== m0)
        $display("FAIL freeze[%0d] got %b/%0d exp %b/%0d", c, hgrant, hmaster, g0, m0);
      else n_pass++;
    end
    hready = 1;
  endtask

  task automatic test_early_term();
    hbusreq = 4'b0100; htrans = 2'b10; hburst = 3'd0; hready = 1;
    tick();
    n_checks++;
    if (hgrant !== 4'b0100) $display("FAIL et_setup got %b exp 0100", hgrant);
    else n_pass++;
    hbusreq = 4'b0101; hburst = 3'd5;
    tick();
    htrans = 2'b11;
    tick();
    tick();
    n_checks++;
    if (hgrant !== 4'b0100) $display("FAIL et_hold got %b exp 0100", hgrant);
    else n_pass++;
    htrans = 2'b00;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001) $display("FAIL et_idle got %b exp 0001", hgrant);
    else n_pass++;
    n_checks++;
    if (hmaster !== 8'd2) $display("FAIL et_hmaster got %0d exp 2", hmaster);
    else n_pass++;
  endtask

  task automatic test_lock();
    hbusreq = 4'b1000; hlock = '0; htrans = 2'b10; hburst = 3'd0; hready = 1;
    tick();
    hbusreq = 4'b1001; hlock = 4'b1000; hburst = 3'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      htrans = 2'b11;
      n_checks++;
      if (hmastlock !== 1'b1 || hgrant !== 4'b1000 || hmaster !== 8'd3)
        $display("FAIL lock_xfer[%0d] got lock=%b grant=%b m=%0d exp lock=1 grant=1000 m=3",
                 c, hmastlock, hgrant, hmaster);
      else n_pass++;
    end
    hlock = '0; hbusreq = 4'b0001; htrans = 2'b00;
    tick();
    n_checks++;
    if (hgrant !== 4'b1000 || hmastlock !== 1'b0)
      $display("FAIL lock_release got grant=%b lock=%b exp grant=1000 lock=0", hgrant, hmastlock);
    else n_pass++;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001) $display("FAIL lock_after got %b exp 0001", hgrant);
    else n_pass++;
  endtask

  task automatic test_idle_bus();
    hbusreq = 4'b0100; hlock = '0; htrans = 2'b10; hburst = 3'd0; hready = 1;
    tick();
    n_checks++;
    if (hgrant !== 4'b0100) $display("FAIL idle_setup got %b exp 0100", hgrant);
    else n_pass++;
    hbusreq = '0; htrans = 2'b00;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (hgrant !== 4'b0001) $display("FAIL idle_hgrant[%0d] got %b exp 0001", c, hgrant);
      else n_pass++;
    end
    n_checks++;
    if (hmaster !== 8'd0) $display("FAIL idle_hmaster got %0d exp 0", hmaster);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    hbusreq = 4'b0010; htrans = 2'b10; hburst = 3'd0; hready = 1;
    tick();
    hburst = 3'd7;
    tick();
    htrans = 2'b11;
    tick();
    n_checks++;
    if (hgrant !== 4'b0010) $display("FAIL rmb_inburst got %b exp 0010", hgrant);
    else n_pass++;
    hreset = 1; hready = 0;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001 || hmaster !== 8'd0 || hmastlock !== 1'b0)
      $display("FAIL rmb_reset got %b/%0d/%b exp 0001/0/0", hgrant, hmaster, hmastlock);
    else n_pass++;
    hreset = 0; hready = 1; htrans = 2'b00; hbusreq = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    for (int c = 0; c < 800; c++) begin
      hreset  = ($urandom_range(0, 99) == 0);
      hbusreq = N'($urandom);
      hlock   = '0;
      for (int b = 0; b < N; b++) hlock[b] = ($urandom_range(0, 7) == 0);
      htrans  = 2'($urandom);
      hburst  = HBW'($urandom);
      hready  = ($urandom_range(0, 3) != 0);
      tick();
      exp_g = N'(1) << m_owner;
      n_checks++;
      if (hgrant !== exp_g) $display("FAIL rnd_hgrant[%0d] got %b exp %b", c, hgrant, exp_g);
      else n_pass++;
      n_checks++;
      if (hmaster !== HMW'(m_hmaster)) $display("FAIL rnd_hmaster[%0d] got %0d exp %0d", c, hmaster, m_hmaster);
      else n_pass++;
      n_checks++;
      if (hmastlock !== m_hmastlock) $display("FAIL rnd_hmastlock[%0d] got %b exp %b", c, hmastlock, m_hmastlock);
      else n_pass++;
    end
    hreset = 0;
  endtask

  initial begin
    hreset = 1; hbusreq = '0; hlock = '0; htrans = 2'b00; hburst = '0; hready = 1;
    model_reset();
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_hready_freeze();
    test_early_term();
    test_lock();
    test_idle_bus();
    test_reset_mid_burst();
    hreset = 1;
    tick();
    hreset = 0;
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
